// File: rtl/csr_pkg.sv
// Shared CSR addresses, write masks and read-forced bits for the M-mode CSR file.
// CSR_COUNTERS_EN selects whether the mcycle/minstret counter addresses are writable.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] ALIGN4_WMASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;

  typedef struct packed {
    logic        en;
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wreq_t;

  function automatic logic [31:0] csr_wmask(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS:         return MSTATUS_WMASK;
      CSR_MTVEC, CSR_MEPC: return ALIGN4_WMASK;
      default:             return 32'hFFFF_FFFF;
    endcase
  endfunction

  // mhartid and unmapped addresses (0x000 from a flushed MEM/WB entry) are not writable
  function automatic logic csr_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL: return 1'b1;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with per-half software write; a write suppresses the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] cnt_q, cnt_d;

  // write-over-increment: the unwritten half holds, no carry crosses into it
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) cnt_d[31:0]  = wdata;
      if (wr_hi) cnt_d[63:32] = wdata;
    end else if (inc) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// RV32 machine-mode CSR file: combinational EX read with WB write-first bypass, sync WB write.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters; otherwise they read 0.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_rd_addr,
  output logic [XLEN-1:0] csr_rd_data,
  output logic            csr_rd_illegal,
  input  logic [11:0]     csr_dest_WB,
  input  logic [XLEN-1:0] csr_wb_data,
  input  logic            csr_wb_en,
  input  logic            instr_retire
);

  csr_wreq_t   wreq;
  logic [31:0] wr_data;
  logic [31:0] wr_view;

  assign wreq    = '{en: csr_wb_en && csr_writable(csr_dest_WB), addr: csr_dest_WB, data: csr_wb_data};
  assign wr_data = wreq.data & csr_wmask(wreq.addr);
  // what the written value reads back as, including mstatus' hardwired MPP
  assign wr_view = wr_data | ((wreq.addr == CSR_MSTATUS) ? MSTATUS_MPP : 32'h0);

  logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (wreq.en) begin
      case (wreq.addr)
        CSR_MSTATUS:  mstatus_q  <= wr_data;
        CSR_MIE:      mie_q      <= wr_data;
        CSR_MTVEC:    mtvec_q    <= wr_data;
        CSR_MSCRATCH: mscratch_q <= wr_data;
        CSR_MEPC:     mepc_q     <= wr_data;
        CSR_MCAUSE:   mcause_q   <= wr_data;
        CSR_MTVAL:    mtval_q    <= wr_data;
        default: ;
      endcase
    end
  end

  logic [63:0] mcycle_v, minstret_v;

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (wreq.en && wreq.addr == CSR_MCYCLE),
    .wr_hi (wreq.en && wreq.addr == CSR_MCYCLEH),
    .wdata (wreq.data),
    .value (mcycle_v)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instr_retire),
    .wr_lo (wreq.en && wreq.addr == CSR_MINSTRET),
    .wr_hi (wreq.en && wreq.addr == CSR_MINSTRETH),
    .wdata (wreq.data),
    .value (minstret_v)
  );
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
  assign mcycle_v      = '0;
  assign minstret_v    = '0;
`endif

  always_comb begin
    csr_rd_data    = '0;
    csr_rd_illegal = 1'b0;
    case (csr_rd_addr)
      CSR_MSTATUS:   csr_rd_data = mstatus_q | MSTATUS_MPP;
      CSR_MIE:       csr_rd_data = mie_q;
      CSR_MTVEC:     csr_rd_data = mtvec_q;
      CSR_MSCRATCH:  csr_rd_data = mscratch_q;
      CSR_MEPC:      csr_rd_data = mepc_q;
      CSR_MCAUSE:    csr_rd_data = mcause_q;
      CSR_MTVAL:     csr_rd_data = mtval_q;
      CSR_MCYCLE:    csr_rd_data = mcycle_v[31:0];
      CSR_MCYCLEH:   csr_rd_data = mcycle_v[63:32];
      CSR_MINSTRET:  csr_rd_data = minstret_v[31:0];
      CSR_MINSTRETH: csr_rd_data = minstret_v[63:32];
      CSR_MHARTID:   csr_rd_data = HART_ID;
      default:       csr_rd_illegal = 1'b1;
    endcase
    // same-cycle WB write to the read address wins, closing the WB->EX hazard
    if (wreq.en && wreq.addr == csr_rd_addr) csr_rd_data = wr_view;
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios plus randomized traffic vs a CSR model.
module tb_csr_regfile;

  localparam logic [31:0] HART = 32'h0000_00A5;
  localparam logic [31:0] MTVR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] csr_rd_addr = '0;
  logic [31:0] csr_rd_data;
  logic        csr_rd_illegal;
  logic [11:0] csr_dest_WB = '0;
  logic [31:0] csr_wb_data = '0;
  logic        csr_wb_en = 1'b0;
  logic        instr_retire = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  csr_regfile #(.XLEN(32), .HART_ID(HART), .MTVEC_RESET(MTVR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr_rd_addr    (csr_rd_addr),
    .csr_rd_data    (csr_rd_data),
    .csr_rd_illegal (csr_rd_illegal),
    .csr_dest_WB    (csr_dest_WB),
    .csr_wb_data    (csr_wb_data),
    .csr_wb_en      (csr_wb_en),
    .instr_retire   (instr_retire)
  );

  always #5 clk = ~clk;

  // model holds each CSR's architectural read value
  logic [31:0] m_status, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addrs [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h000, 12'h7C0,
                              12'h301, 12'hB01};

  function automatic bit tb_wr(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343: return 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] tb_view(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300:          return (v & 32'h0000_0088) | 32'h0000_1800;
      12'h305, 12'h341: return {v[31:2], 2'b00};
      default:          return v;
    endcase
  endfunction

  // {illegal, data} expected on the read port given model state and current WB inputs
  function automatic logic [32:0] exp_rd(input logic [11:0] a);
    if (csr_wb_en && csr_dest_WB == a && tb_wr(a)) return {1'b0, tb_view(a, csr_wb_data)};
    case (a)
      12'h300: return {1'b0, m_status};
      12'h304: return {1'b0, m_mie};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'h343: return {1'b0, m_mtval};
      12'hB00: return {1'b0, m_cycle[31:0]};
      12'hB80: return {1'b0, m_cycle[63:32]};
      12'hB02: return {1'b0, m_instret[31:0]};
      12'hB82: return {1'b0, m_instret[63:32]};
      12'hF14: return {1'b0, HART};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic mdl_reset();
    m_status = 32'h0000_1800; m_mie = '0; m_mtvec = MTVR; m_mscratch = '0;
    m_mepc = '0; m_mcause = '0; m_mtval = '0; m_cycle = '0; m_instret = '0;
  endtask

  task automatic mdl_clk();
    logic [63:0] nc, ni;
    bit wc, wi;
    nc = m_cycle; ni = m_instret; wc = 0; wi = 0;
    if (csr_wb_en && tb_wr(csr_dest_WB)) begin
      case (csr_dest_WB)
        12'h300: m_status   = tb_view(12'h300, csr_wb_data);
        12'h304: m_mie      = csr_wb_data;
        12'h305: m_mtvec    = tb_view(12'h305, csr_wb_data);
        12'h340: m_mscratch = csr_wb_data;
        12'h341: m_mepc     = tb_view(12'h341, csr_wb_data);
        12'h342: m_mcause   = csr_wb_data;
        12'h343: m_mtval    = csr_wb_data;
        12'hB00: begin nc[31:0]  = csr_wb_data; wc = 1; end
        12'hB80: begin nc[63:32] = csr_wb_data; wc = 1; end
        12'hB02: begin ni[31:0]  = csr_wb_data; wi = 1; end
        12'hB82: begin ni[63:32] = csr_wb_data; wi = 1; end
        default: ;
      endcase
    end
`ifdef CSR_COUNTERS_EN
    m_cycle   = wc ? nc : m_cycle + 64'd1;
    m_instret = wi ? ni : (instr_retire ? m_instret + 64'd1 : m_instret);
`endif
  endtask

  // advance one clock with the model following; returns at the next falling edge
  task automatic cyc();
    @(posedge clk);
    if (rst_n) mdl_clk();
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a);
    csr_rd_addr = a;
    #1;
  endtask

  task automatic wb(input bit en, input logic [11:0] a, input logic [31:0] d);
    csr_wb_en = en; csr_dest_WB = a; csr_wb_data = d;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      wb(1'b1, addrs[$urandom_range(0, 10)], $urandom);
      instr_retire = 1'($urandom);
      cyc();
    end
    #2;
    rst_n = 1'b0;
    mdl_reset();
    wb(1'b0, 12'h0, 32'h0);
    instr_retire = 1'b0;
    rd(12'h300);
    n_chk++; if (csr_rd_data !== 32'h0000_1800) $display("FAIL reset_async_mstatus: got %h want %h", csr_rd_data, 32'h0000_1800); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd(12'h300);
    n_chk++; if (csr_rd_data !== 32'h0000_1800) $display("FAIL reset_mstatus: got %h want %h", csr_rd_data, 32'h0000_1800); else n_pass++;
    n_chk++; if (csr_rd_illegal !== 1'b0) $display("FAIL reset_illegal_300: got %b want 0", csr_rd_illegal); else n_pass++;
    rd(12'h305);
    n_chk++; if (csr_rd_data !== MTVR) $display("FAIL reset_mtvec: got %h want %h", csr_rd_data, MTVR); else n_pass++;
    rd(12'hB00);
    n_chk++; if (csr_rd_data !== 32'h0) $display("FAIL reset_mcycle: got %h want 0", csr_rd_data); else n_pass++;
    rd(12'h7C0);
    n_chk++; if (csr_rd_illegal !== 1'b1) $display("FAIL reset_illegal_7c0: got %b want 1", csr_rd_illegal); else n_pass++;
    cyc();
  endtask

  task automatic test_masked();
    wb(1'b1, 12'h300, 32'hFFFF_FFFF);
    csr_rd_addr = 12'h304;
    cyc();
    wb(1'b0, 12'h0, 32'h0);
    rd(12'h300);
    n_chk++; if (csr_rd_data !== 32'h0000_1888) $display("FAIL mask_mstatus: got %h want %h", csr_rd_data, 32'h0000_1888); else n_pass++;
    wb(1'b1, 12'h341, 32'h8000_0003);
    csr_rd_addr = 12'h304;
    cyc();
    wb(1'b0, 12'h0, 32'h0);
    rd(12'h341);
    n_chk++; if (csr_rd_data !== 32'h8000_0000) $display("FAIL mask_mepc: got %h want %h", csr_rd_data, 32'h8000_0000); else n_pass++;
  endtask

  task automatic test_unmapped();
    wb(1'b1, 12'h000, 32'hDEAD_BEEF);
    rd(12'h000);
    n_chk++; if (csr_rd_data !== 32'h0 || csr_rd_illegal !== 1'b1)
      $display("FAIL flush_read_000: got %h/%b want 0/1", csr_rd_data, csr_rd_illegal); else n_pass++;
    cyc();
    wb(1'b1, 12'hF14, 32'hDEAD_BEEF);
    rd(12'hF14);
    n_chk++; if (csr_rd_data !== HART) $display("FAIL hartid_nobypass: got %h want %h", csr_rd_data, HART); else n_pass++;
    cyc();
    wb(1'b0, 12'h0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      logic [32:0] e;
      rd(addrs[i]);
      e = exp_rd(addrs[i]);
      n_chk++; if (csr_rd_data !== e[31:0]) $display("FAIL unmapped_keep %h: got %h want %h", addrs[i], csr_rd_data, e[31:0]); else n_pass++;
      cyc();
    end
    rd(12'hF14);
    n_chk++; if (csr_rd_data !== HART) $display("FAIL hartid_after: got %h want %h", csr_rd_data, HART); else n_pass++;
  endtask

  task automatic test_bypass();
    wb(1'b1, 12'h340, 32'h1234_5678);
    rd(12'h340);
    n_chk++; if (csr_rd_data !== 32'h1234_5678) $display("FAIL bypass_same: got %h want %h", csr_rd_data, 32'h1234_5678); else n_pass++;
    cyc();
    wb(1'b0, 12'h0, 32'h0);
    rd(12'h340);
    n_chk++; if (csr_rd_data !== 32'h1234_5678) $display("FAIL bypass_next: got %h want %h", csr_rd_data, 32'h1234_5678); else n_pass++;
    wb(1'b1, 12'h300, 32'hFFFF_FF77);
    rd(12'h300);
    n_chk++; if (csr_rd_data !== 32'h0000_1800) $display("FAIL bypass_mstatus: got %h want %h", csr_rd_data, 32'h0000_1800); else n_pass++;
    cyc();
    wb(1'b0, 12'h0, 32'h0);
  endtask

`ifdef CSR_COUNTERS_EN
  task automatic test_counters();
    logic [31:0] hi, v;
    wb(1'b1, 12'hB00, 32'hFFFF_FFFE);
    cyc();
    wb(1'b0, 12'h0, 32'h0);
    hi = m_cycle[63:32];
    rd(12'hB00);
    n_chk++; if (csr_rd_data !== 32'hFFFF_FFFE) $display("FAIL cnt_write_lo: got %h want %h", csr_rd_data, 32'hFFFF_FFFE); else n_pass++;
    cyc();
    rd(12'hB00);
    n_chk++; if (csr_rd_data !== 32'hFFFF_FFFF) $display("FAIL cnt_inc_lo: got %h want %h", csr_rd_data, 32'hFFFF_FFFF); else n_pass++;
    rd(12'hB80);
    n_chk++; if (csr_rd_data !== hi) $display("FAIL cnt_hi_hold: got %h want %h", csr_rd_data, hi); else n_pass++;
    cyc();
    rd(12'hB00);
    n_chk++; if (csr_rd_data !== 32'h0) $display("FAIL cnt_lo_wrap: got %h want 0", csr_rd_data); else n_pass++;
    rd(12'hB80);
    n_chk++; if (csr_rd_data !== hi + 32'd1) $display("FAIL cnt_carry: got %h want %h", csr_rd_data, hi + 32'd1); else n_pass++;
    wb(1'b1, 12'hB80, 32'hFFFF_FFFF);
    cyc();
    wb(1'b1, 12'hB00, 32'hFFFF_FFFF);
    cyc();
    wb(1'b0, 12'h0, 32'h0);
    rd(12'hB80);
    n_chk++; if (csr_rd_data !== 32'hFFFF_FFFF) $display("FAIL cnt_max_hi: got %h want %h", csr_rd_data, 32'hFFFF_FFFF); else n_pass++;
    cyc();
    rd(12'hB00);
    n_chk++; if (csr_rd_data !== 32'h0) $display("FAIL cnt_wrap64_lo: got %h want 0", csr_rd_data); else n_pass++;
    rd(12'hB80);
    n_chk++; if (csr_rd_data !== 32'h0) $display("FAIL cnt_wrap64_hi: got %h want 0", csr_rd_data); else n_pass++;
    v = $urandom;
    instr_retire = 1'b1;
    wb(1'b1, 12'hB02, v);
    cyc();
    wb(1'b0, 12'h0, 32'h0);
    rd(12'hB02);
    n_chk++; if (csr_rd_data !== v) $display("FAIL instret_write_wins: got %h want %h", csr_rd_data, v); else n_pass++;
    cyc();
    instr_retire = 1'b0;
    rd(12'hB02);
    n_chk++; if (csr_rd_data !== v + 32'd1) $display("FAIL instret_inc: got %h want %h", csr_rd_data, v + 32'd1); else n_pass++;
  endtask
`else
  task automatic test_feature_off();
    for (int i = 0; i < 10; i++) begin
      instr_retire = 1'b1; cyc();
      instr_retire = 1'b0; cyc();
    end
    rd(12'hB02);
    n_chk++; if (csr_rd_data !== 32'h0) $display("FAIL off_instret: got %h want 0", csr_rd_data); else n_pass++;
    n_chk++; if (csr_rd_illegal !== 1'b0) $display("FAIL off_illegal: got %b want 0", csr_rd_illegal); else n_pass++;
    wb(1'b1, 12'hB00, 32'h1234_5678);
    rd(12'hB00);
    n_chk++; if (csr_rd_data !== 32'h0) $display("FAIL off_nobypass: got %h want 0", csr_rd_data); else n_pass++;
    cyc();
    wb(1'b0, 12'h0, 32'h0);
    rd(12'hB00);
    n_chk++; if (csr_rd_data !== 32'h0) $display("FAIL off_write_drop: got %h want 0", csr_rd_data); else n_pass++;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [32:0] e;
      wb(1'($urandom_range(0, 3) != 0), addrs[$urandom_range(0, 15)], $urandom);
      instr_retire = 1'($urandom);
      rd(($urandom_range(0, 2) == 0) ? csr_dest_WB : addrs[$urandom_range(0, 15)]);
      e = exp_rd(csr_rd_addr);
      n_chk++; if (csr_rd_data !== e[31:0] || csr_rd_illegal !== e[32])
        $display("FAIL random %0d addr %h: got %h/%b want %h/%b", i, csr_rd_addr, csr_rd_data, csr_rd_illegal, e[31:0], e[32]);
      else n_pass++;
      cyc();
    end
    wb(1'b0, 12'h0, 32'h0);
    instr_retire = 1'b0;
  endtask

  initial begin
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_masked();
    test_unmapped();
    test_bypass();
`ifdef CSR_COUNTERS_EN
    test_counters();
`else
    test_feature_off();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
